// File: rtl/riscv_test_monitor_if.sv
// riscv_test_monitor_if
// Groups the core-side signals the end-of-test monitor observes.
//   run_en    : core running, monitor armed
//   retire    : one instruction retires this cycle
//   pc        : PC of the retiring instruction
//   gp        : current value of x3
//   mem_we    : data store strobe
//   mem_addr  : store address
//   mem_wdata : store data
// master : the core (or bench) driving the stream
// slave  : the monitor observing it
interface riscv_test_monitor_if;
  logic        run_en;
  logic        retire;
  logic [31:0] pc;
  logic [31:0] gp;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output run_en, retire, pc, gp, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input run_en, retire, pc, gp, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
// End-of-test detector for riscv-tests runs. Watches the retire stream and
// store port, and reports pass / fail / timeout as registered verdicts.
// Ports:
//   clk      : single clock, rising edge
//   rst      : asynchronous active-low reset
//   bus      : core-side retire/store stream (slave modport)
//   done     : any verdict reached
//   pass     : test passed (result == 1)
//   fail     : test failed
//   timeout  : no verdict within TIMEOUT_CYCLES RUN edges
//   test_num : result[31:1] while failed, else 0
//   cycles   : RUN-state edge count, frozen once RUN is left
module riscv_test_monitor #(
  parameter logic [31:0] END_PC         = 32'h0000_0044,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter bit          USE_TOHOST     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_test_monitor_if.slave   bus,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [30:0]           test_num,
  output logic [CNT_W-1:0]      cycles
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_CHECK   = 3'd2,
    S_PASS    = 3'd3,
    S_FAIL    = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  // Pre-edge count on the last RUN edge before a timeout verdict.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cycles_r;
  logic [31:0]        result_r;
  logic               done_r;
  logic               pass_r;
  logic               fail_r;
  logic               timeout_r;
  logic [30:0]        test_num_r;

  logic               tohost_hit_s;
  logic               pc_hit_s;
  logic               limit_hit_s;
  logic               pass_nxt_s;
  logic               fail_nxt_s;
  logic               timeout_nxt_s;
  logic [30:0]        test_num_nxt_s;

  // A zero store to tohost is not a verdict; a PC match only counts on retire.
  assign tohost_hit_s = USE_TOHOST && bus.mem_we &&
                        (bus.mem_addr == TOHOST_ADDR) && (bus.mem_wdata != 32'h0000_0000);
  assign pc_hit_s     = bus.retire && (bus.pc == END_PC);
  assign limit_hit_s  = (cycles_r == CNT_LAST);

  // State and verdict output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      fail_r     <= 1'b0;
      timeout_r  <= 1'b0;
      test_num_r <= 31'h0;
    end else begin
      state_r    <= state_nxt_s;
      done_r     <= pass_nxt_s | fail_nxt_s | timeout_nxt_s;
      pass_r     <= pass_nxt_s;
      fail_r     <= fail_nxt_s;
      timeout_r  <= timeout_nxt_s;
      test_num_r <= test_num_nxt_s;
    end
  end

  // Next-state selection; triggers beat timeout, tohost beats the PC trigger.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.run_en) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (tohost_hit_s || pc_hit_s) begin
          state_nxt_s = S_CHECK;
        end else if (limit_hit_s) begin
          state_nxt_s = S_TIMEOUT;
        end else if (!bus.run_en) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_CHECK: begin
        if (result_r == 32'h0000_0001) begin
          state_nxt_s = S_PASS;
        end else begin
          state_nxt_s = S_FAIL;
        end
      end
      S_PASS:    state_nxt_s = S_PASS;
      S_FAIL:    state_nxt_s = S_FAIL;
      S_TIMEOUT: state_nxt_s = S_TIMEOUT;
      default:   state_nxt_s = S_IDLE;
    endcase
  end

  // Verdict decode from the next state so the outputs land with the state.
  always_comb begin
    pass_nxt_s     = (state_nxt_s == S_PASS);
    fail_nxt_s     = (state_nxt_s == S_FAIL);
    timeout_nxt_s  = (state_nxt_s == S_TIMEOUT);
    test_num_nxt_s = 31'h0;
    if (state_nxt_s == S_FAIL) begin
      test_num_nxt_s = result_r[31:1];
    end else begin
      test_num_nxt_s = 31'h0;
    end
  end

  // Cycle counter and captured result; both reset on every IDLE->RUN arm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_r <= {CNT_W{1'b0}};
      result_r <= 32'h0000_0000;
    end else if ((state_r == S_IDLE) && bus.run_en) begin
      cycles_r <= {CNT_W{1'b0}};
      result_r <= 32'h0000_0000;
    end else if (state_r == S_RUN) begin
      if (cycles_r != CNT_MAX) begin
        cycles_r <= cycles_r + CNT_W'(1);
      end
      if (tohost_hit_s) begin
        result_r <= bus.mem_wdata;
      end else if (pc_hit_s) begin
        result_r <= bus.gp;
      end
    end
  end

  assign done     = done_r;
  assign pass     = pass_r;
  assign fail     = fail_r;
  assign timeout  = timeout_r;
  assign test_num = test_num_r;
  assign cycles   = cycles_r;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor. dut_a uses tohost detection,
// dut_b has it disabled; both share the stimulus bus and use a 20-cycle
// timeout so the timeout boundary is reachable.
module tb_riscv_test_monitor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_test_monitor_if bus();

  logic        done_a, pass_a, fail_a, timeout_a;
  logic [30:0] test_num_a;
  logic [31:0] cycles_a;
  logic        done_b, pass_b, fail_b, timeout_b;
  logic [30:0] test_num_b;
  logic [31:0] cycles_b;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_test_monitor #(
    .END_PC(32'h0000_0044), .TOHOST_ADDR(32'h0000_1000), .USE_TOHOST(1'b1),
    .TIMEOUT_CYCLES(20), .CNT_W(32)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus),
    .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(timeout_a),
    .test_num(test_num_a), .cycles(cycles_a)
  );

  riscv_test_monitor #(
    .END_PC(32'h0000_0044), .TOHOST_ADDR(32'h0000_1000), .USE_TOHOST(1'b0),
    .TIMEOUT_CYCLES(20), .CNT_W(32)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus),
    .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(timeout_b),
    .test_num(test_num_b), .cycles(cycles_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic d, input logic p, input logic f,
                         input logic t, input logic [30:0] tn, input logic [31:0] cy);
    check({tag, ".done"},     64'(done_a),     64'(d));
    check({tag, ".pass"},     64'(pass_a),     64'(p));
    check({tag, ".fail"},     64'(fail_a),     64'(f));
    check({tag, ".timeout"},  64'(timeout_a),  64'(t));
    check({tag, ".test_num"}, 64'(test_num_a), 64'(tn));
    check({tag, ".cycles"},   64'(cycles_a),   64'(cy));
  endtask

  // Advance one edge; return 1 time unit after it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.run_en    = 1'b0;
    bus.retire    = 1'b0;
    bus.pc        = 32'h0;
    bus.gp        = 32'h0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
  endtask

  // Called 1 unit after an edge; reset spans one edge, release away from it.
  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // IDLE->RUN edge: afterwards state is RUN with cycles = 0.
  task automatic start_run();
    bus.run_en = 1'b1;
    tick();
  endtask

  task automatic pc_trigger(input logic [31:0] g);
    bus.retire = 1'b1;
    bus.pc     = 32'h0000_0044;
    bus.gp     = g;
    tick();
    bus.retire = 1'b0;
    bus.pc     = 32'h0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #1;
    check_a("reset", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd0);
    tick();
    tick();
    rst = 1'b1;

    // Pass via PC, with pc=END_PC but retire=0 on the earlier edges.
    start_run();
    check("arm.cycles", 64'(cycles_a), 64'd0);
    bus.pc = 32'h0000_0044;
    repeat (10) tick();
    check_a("no_retire", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd10);
    pc_trigger(32'h1);
    check_a("check_state", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd11);
    tick();
    check_a("pass_pc", 1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'd11);

    // Inputs toggled in PASS must not move anything.
    bus.run_en = 1'b0; bus.retire = 1'b1; bus.pc = 32'h44; bus.gp = 32'h7;
    bus.mem_we = 1'b1; bus.mem_addr = 32'h1000; bus.mem_wdata = 32'h3;
    tick();
    bus.run_en = 1'b1;
    repeat (2) tick();
    check_a("pass_hold", 1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'd11);

    // Async reset while in PASS, between edges.
    rst = 1'b0;
    #1;
    check_a("rst_in_pass", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd0);
    idle_inputs();
    tick();
    rst = 1'b1;

    // Fail via PC: gp=7 -> test_num 3.
    start_run();
    repeat (10) tick();
    pc_trigger(32'h7);
    tick();
    check_a("fail_gp7", 1'b1, 1'b0, 1'b1, 1'b0, 31'd3, 32'd11);

    // Fail via PC: gp=0 -> test_num 0.
    pulse_reset();
    start_run();
    repeat (10) tick();
    pc_trigger(32'h0);
    tick();
    check_a("fail_gp0", 1'b1, 1'b0, 1'b1, 1'b0, 31'd0, 32'd11);

    // tohost: zero store ignored, then combined tohost+PC edge.
    pulse_reset();
    start_run();
    repeat (2) tick();
    bus.mem_we = 1'b1; bus.mem_addr = 32'h1000; bus.mem_wdata = 32'h0;
    tick();
    bus.mem_we = 1'b0;
    tick();
    check_a("tohost_zero", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd4);
    bus.mem_we = 1'b1; bus.mem_addr = 32'h1000; bus.mem_wdata = 32'h1;
    bus.retire = 1'b1; bus.pc = 32'h44; bus.gp = 32'h5;
    tick();
    idle_inputs();
    bus.run_en = 1'b1;
    tick();
    check_a("tohost_prio", 1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'd5);
    check("no_tohost.fail",     64'(fail_b),     64'd1);
    check("no_tohost.pass",     64'(pass_b),     64'd0);
    check("no_tohost.test_num", 64'(test_num_b), 64'd2);

    // Timeout boundary at 20 RUN edges.
    pulse_reset();
    start_run();
    repeat (19) tick();
    check_a("pre_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd19);
    tick();
    check_a("timeout", 1'b1, 1'b0, 1'b0, 1'b1, 31'd0, 32'd20);

    // Trigger on the 20th edge beats the timeout.
    pulse_reset();
    start_run();
    repeat (19) tick();
    pc_trigger(32'h1);
    check_a("trig_at_limit", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd20);
    tick();
    check_a("pass_at_limit", 1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'd20);

    // Abort: 6 armed RUN edges plus the run_en=0 edge, which still counts.
    pulse_reset();
    start_run();
    repeat (6) tick();
    bus.run_en = 1'b0;
    tick();
    check_a("abort", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd7);
    repeat (3) tick();
    check("abort_hold.cycles", 64'(cycles_a), 64'd7);
    start_run();
    check("rearm.cycles", 64'(cycles_a), 64'd0);
    repeat (3) tick();
    check("rearm3.cycles", 64'(cycles_a), 64'd3);

    // Async reset while in CHECK.
    pc_trigger(32'h1);
    check("in_check.cycles", 64'(cycles_a), 64'd4);
    rst = 1'b0;
    #1;
    check_a("rst_in_check", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd0);
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    check_a("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd0);

    // Fresh pass run after reset behaves as the first one.
    start_run();
    repeat (10) tick();
    pc_trigger(32'h1);
    tick();
    check_a("pass_again", 1'b1, 1'b1, 1'b0, 1'b0, 31'd0, 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
